// File: rtl/neo_frame_scheduler.sv
// neo_frame_scheduler: stages 8 RGB pixels, scales them into a stable shadow set and launches the NeoPixel driver (optional scaler: NEO_BRIGHTNESS_EN)
module neo_frame_scheduler #(
    parameter int REFRESH_TICKS = 833333,
    parameter int CNT_W = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_wr_en,
    input  logic [2:0]  pix_wr_idx,
    input  logic [23:0] pix_wr_data,
    input  logic [7:0]  brightness,
    input  logic        commit,
    input  logic        auto_refresh_en,
    input  logic        drv_busy,
    output logic        drv_start,
    output logic [23:0] pixel1,
    output logic [23:0] pixel2,
    output logic [23:0] pixel3,
    output logic [23:0] pixel4,
    output logic [23:0] pixel5,
    output logic [23:0] pixel6,
    output logic [23:0] pixel7,
    output logic [23:0] pixel8,
    output logic        pending,
    output logic        frame_done,
    output logic        frame_err
);
    typedef enum logic [2:0] {IDLE, SCALE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_next;
    logic [2:0] idx;
    logic [1:0] wcnt;
    logic [CNT_W-1:0] rcnt;
    logic refresh_hit, take, start_next, done_next, err_next;
    logic [23:0] scaled;
    logic [23:0] stg [8];
    logic [23:0] shadow [8];

`ifdef NEO_BRIGHTNESS_EN
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'd0, c} * ({9'd0, b} + 17'd1);
        return p[15:8];
    endfunction
    // per-channel brightness scaling of the staging entry being copied this SCALE cycle
    always_comb scaled = {scale_ch(stg[idx][23:16], brightness), scale_ch(stg[idx][15:8], brightness), scale_ch(stg[idx][7:0], brightness)};
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign scaled = stg[idx];
`endif

    assign refresh_hit = auto_refresh_en && rcnt == CNT_W'(REFRESH_TICKS - 1);
    assign take = state == IDLE && state_next == SCALE;
    assign pixel1 = shadow[0];
    assign pixel2 = shadow[1];
    assign pixel3 = shadow[2];
    assign pixel4 = shadow[3];
    assign pixel5 = shadow[4];
    assign pixel6 = shadow[5];
    assign pixel7 = shadow[6];
    assign pixel8 = shadow[7];

    // frame sequencing: next state and the one-cycle pulses to be registered
    always_comb begin
        state_next = state;
        start_next = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE:      state_next = ((pending || commit) && !drv_busy) ? SCALE : IDLE;
            SCALE: begin
                state_next = (idx == 3'd7) ? LAUNCH : SCALE;
                start_next = idx == 3'd7;
            end
            LAUNCH:    state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                state_next = drv_busy ? WAIT_DONE : (wcnt == 2'd3) ? IDLE : WAIT_BUSY;
                err_next   = !drv_busy && wcnt == 2'd3;
            end
            WAIT_DONE: begin
                state_next = drv_busy ? WAIT_DONE : IDLE;
                done_next  = !drv_busy;
            end
            default:   state_next = IDLE;
        endcase
    end

    // state, counters, request flag, staging writes and shadow updates
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            wcnt       <= 2'd0;
            rcnt       <= '0;
            pending    <= 1'b0;
            drv_start  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                stg[i]    <= 24'd0;
                shadow[i] <= 24'd0;
            end
        end else begin
            state      <= state_next;
            idx        <= (state == SCALE) ? idx + 3'd1 : 3'd0;
            wcnt       <= (state == WAIT_BUSY) ? wcnt + 2'd1 : 2'd0;
            rcnt       <= (!auto_refresh_en || refresh_hit) ? '0 : rcnt + CNT_W'(1);
            pending    <= (pending && !take) || commit || refresh_hit;
            drv_start  <= start_next;
            frame_done <= done_next;
            frame_err  <= err_next;
            if (pix_wr_en) stg[pix_wr_idx] <= pix_wr_data;
            if (state == SCALE) shadow[idx] <= scaled;
        end
    end
endmodule
